// File: rtl/nanorv32_busarb_if.sv
// Bus bundle for the nanorv32 two-master arbiter: the I-side (fetch) and
// D-side (load/store) request ports plus the shared slave port.
// The "master" modport is the arbiter's view: it masters the shared slave
// port and answers the two core-side requesters. The "slave" modport is
// the complementary environment view (core masters plus the slave memory).
interface nanorv32_busarb_if;
    // I-side fetch port
    logic        htransi;
    logic [31:0] haddri;
    logic        hreadyi;
    logic [31:0] hrdatai;
    // D-side load/store port
    logic        htransd;
    logic        hwrited;
    logic [31:0] haddrd;
    logic [2:0]  hsized;
    logic [31:0] hwdatad;
    logic        hreadyd;
    logic [31:0] hrdatad;
    // Shared slave port
    logic        htranss;
    logic        hwrites;
    logic [31:0] haddrs;
    logic [2:0]  hsizes;
    logic [31:0] hwdatas;
    logic        hreadys;
    logic [31:0] hrdatas;

    modport master (
        input  htransi, haddri,
        output hreadyi, hrdatai,
        input  htransd, hwrited, haddrd, hsized, hwdatad,
        output hreadyd, hrdatad,
        output htranss, hwrites, haddrs, hsizes, hwdatas,
        input  hreadys, hrdatas
    );

    modport slave (
        output htransi, haddri,
        input  hreadyi, hrdatai,
        output htransd, hwrited, haddrd, hsized, hwdatad,
        input  hreadyd, hrdatad,
        input  htranss, hwrites, haddrs, hsizes, hwdatas,
        output hreadys, hrdatas
    );
endinterface

// File: rtl/nanorv32_busarb.sv
// Two-master to one-slave bus arbiter for nanorv32. One transfer is in
// flight at a time (IDLE -> ADDR -> DATA). The D-side wins contention
// until it has taken MAX_D_STREAK grants in a row while the I-side waited,
// after which the I-side is served, so fetch can never starve.
module nanorv32_busarb #(
    parameter int MAX_D_STREAK = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    nanorv32_busarb_if.master    bus
);

    localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t        state_reg;
    logic          owner_d_reg;
    logic [SW-1:0] streak_reg;
    logic [31:0]   addr_reg;
    logic [2:0]    size_reg;
    logic [31:0]   wdata_reg;
    logic          htranss_reg;
    logic          hwrites_reg;

    logic grant_d;
    logic grant_i;
    logic done;

    // Grant decision for the IDLE cycle and the completion strobe; the
    // strobe is masked during reset so an aborted transfer never completes.
    always_comb begin
        grant_d = bus.htransd && (!bus.htransi || (streak_reg != STREAK_MAX));
        grant_i = bus.htransi && !grant_d;
        done    = !rst && (state_reg == DATA) && bus.hreadys;
    end

    assign bus.htranss = htranss_reg;
    assign bus.hwrites = hwrites_reg;
    assign bus.haddrs  = addr_reg;
    assign bus.hsizes  = size_reg;
    assign bus.hwdatas = wdata_reg;

    // A master that is not requesting always sees ready; a requesting one
    // only sees ready (and the slave's read data) on its own completion.
    assign bus.hreadyi = !bus.htransi || (done && !owner_d_reg);
    assign bus.hreadyd = !bus.htransd || (done && owner_d_reg);
    assign bus.hrdatai = (done && !owner_d_reg) ? bus.hrdatas : 32'h0;
    assign bus.hrdatad = (done && owner_d_reg)  ? bus.hrdatas : 32'h0;

    // Transfer sequencing, request latching and D-streak bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            owner_d_reg <= 1'b0;
            streak_reg  <= '0;
            addr_reg    <= 32'h0;
            size_reg    <= 3'b000;
            wdata_reg   <= 32'h0;
            htranss_reg <= 1'b0;
            hwrites_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_d || grant_i) begin
                        state_reg   <= ADDR;
                        htranss_reg <= 1'b1;
                        owner_d_reg <= grant_d;
                        if (grant_d) begin
                            addr_reg    <= bus.haddrd;
                            size_reg    <= bus.hsized;
                            wdata_reg   <= bus.hwdatad;
                            hwrites_reg <= bus.hwrited;
                        end else begin
                            // Fetches are always 32-bit reads.
                            addr_reg    <= bus.haddri;
                            size_reg    <= 3'b010;
                            wdata_reg   <= 32'h0;
                            hwrites_reg <= 1'b0;
                        end
                        // Only D grants taken while fetch waits extend the streak.
                        if (grant_d && bus.htransi) begin
                            if (streak_reg != STREAK_MAX) begin
                                streak_reg <= streak_reg + 1'b1;
                            end
                        end else begin
                            streak_reg <= '0;
                        end
                    end
                end
                ADDR: begin
                    state_reg   <= DATA;
                    htranss_reg <= 1'b0;
                end
                DATA: begin
                    if (bus.hreadys) begin
                        state_reg   <= IDLE;
                        hwrites_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    htranss_reg <= 1'b0;
                    hwrites_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nanorv32_busarb.sv
// Directed bench for nanorv32_busarb: reset values, single fetch, D write
// with wait states, D/I fairness, reset abort and post-grant address hold.
module tb_nanorv32_busarb;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fails  = 0;

    nanorv32_busarb_if bus ();

    nanorv32_busarb #(.MAX_D_STREAK(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Move to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic        exp_d;

        rst         = 1'b1;
        bus.htransi = 1'b0;
        bus.haddri  = 32'h0;
        bus.htransd = 1'b0;
        bus.hwrited = 1'b0;
        bus.haddrd  = 32'h0;
        bus.hsized  = 3'b000;
        bus.hwdatad = 32'h0;
        bus.hreadys = 1'b0;
        bus.hrdatas = 32'h0;

        // Reset state
        tick();
        tick();
        #1;
        chk("rst_hreadyi", 32'(bus.hreadyi), 32'h1);
        chk("rst_hreadyd", 32'(bus.hreadyd), 32'h1);
        chk("rst_htranss", 32'(bus.htranss), 32'h0);
        chk("rst_hwrites", 32'(bus.hwrites), 32'h0);
        chk("rst_haddrs",  bus.haddrs,       32'h0);
        chk("rst_hrdatai", bus.hrdatai,      32'h0);
        bus.htransi = 1'b1;
        #1;
        chk("rst_hreadyi_req", 32'(bus.hreadyi), 32'h0);
        tick();
        rst         = 1'b0;
        bus.htransi = 1'b0;

        // Single fetch of 0x100, zero wait states
        tick();
        bus.htransi = 1'b1;
        bus.haddri  = 32'h100;
        bus.hreadys = 1'b1;
        bus.hrdatas = 32'h00000013;
        #1;
        chk("i_wait_idle", 32'(bus.hreadyi), 32'h0);
        tick();
        chk("i_htranss",   32'(bus.htranss), 32'h1);
        chk("i_haddrs",    bus.haddrs,       32'h100);
        chk("i_hsizes",    32'(bus.hsizes),  32'h2);
        chk("i_hwrites",   32'(bus.hwrites), 32'h0);
        chk("i_hready_a",  32'(bus.hreadyi), 32'h0);
        tick();
        chk("i_hreadyi",   32'(bus.hreadyi), 32'h1);
        chk("i_hrdatai",   bus.hrdatai,      32'h00000013);
        chk("i_hrdatad",   bus.hrdatad,      32'h0);
        chk("i_htranss_d", 32'(bus.htranss), 32'h0);
        bus.htransi = 1'b0;
        tick();
        chk("i_idle_trans", 32'(bus.htranss), 32'h0);

        // D write with three slave wait states
        bus.htransd = 1'b1;
        bus.hwrited = 1'b1;
        bus.haddrd  = 32'h20000004;
        bus.hsized  = 3'b010;
        bus.hwdatad = 32'hCAFFE000;
        bus.hreadys = 1'b0;
        tick();
        chk("d_htranss",   32'(bus.htranss), 32'h1);
        chk("d_hwrites",   32'(bus.hwrites), 32'h1);
        chk("d_haddrs",    bus.haddrs,       32'h20000004);
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("d_ws_hwdatas", bus.hwdatas,      32'hCAFFE000);
            chk("d_ws_hreadyd", 32'(bus.hreadyd), 32'h0);
            chk("d_ws_htranss", 32'(bus.htranss), 32'h0);
        end
        tick();
        bus.hreadys = 1'b1;
        bus.hrdatas = 32'h0000AA55;
        #1;
        chk("d_hwdatas",   bus.hwdatas,      32'hCAFFE000);
        chk("d_hreadyd",   32'(bus.hreadyd), 32'h1);
        chk("d_hrdatad",   bus.hrdatad,      32'h0000AA55);
        chk("d_hrdatai",   bus.hrdatai,      32'h0);
        bus.htransd = 1'b0;
        bus.hwrited = 1'b0;
        tick();
        chk("d_idle_hwrites", 32'(bus.hwrites), 32'h0);
        chk("d_idle_hwdatas", bus.hwdatas,      32'hCAFFE000);
        chk("d_idle_hreadyd", 32'(bus.hreadyd), 32'h1);

        // Continuous I and D requests: expect D,D,I,D,D,I
        bus.htransi = 1'b1;
        bus.haddri  = 32'h10;
        bus.htransd = 1'b1;
        bus.haddrd  = 32'hD0;
        bus.hreadys = 1'b1;
        bus.hrdatas = 32'h12345678;
        for (int g = 0; g < 6; g++) begin
            exp_d    = (g % 3) != 2;
            exp_addr = exp_d ? 32'hD0 : 32'h10;
            tick();
            chk("arb_grant_addr", bus.haddrs, exp_addr);
            tick();
            chk("arb_hreadyd", 32'(bus.hreadyd), 32'(exp_d));
            chk("arb_hreadyi", 32'(bus.hreadyi), 32'(!exp_d));
            if (g == 5) begin
                bus.htransi = 1'b0;
                bus.htransd = 1'b0;
            end
            tick();
        end

        // Reset in DATA with the slave stalled aborts the transfer
        bus.htransd = 1'b1;
        bus.haddrd  = 32'h44;
        bus.hreadys = 1'b0;
        tick();
        chk("ra_htranss", 32'(bus.htranss), 32'h1);
        tick();
        rst = 1'b1;
        #1;
        chk("ra_hreadyd_rst", 32'(bus.hreadyd), 32'h0);
        chk("ra_hrdatad_rst", bus.hrdatad,      32'h0);
        tick();
        rst         = 1'b0;
        bus.hreadys = 1'b1;
        bus.hrdatas = 32'h00000077;
        #1;
        chk("ra_htranss_idle", 32'(bus.htranss), 32'h0);
        chk("ra_hreadyd_idle", 32'(bus.hreadyd), 32'h0);
        chk("ra_haddrs_clr",   bus.haddrs,       32'h0);
        tick();
        chk("ra_regrant",      32'(bus.htranss), 32'h1);
        chk("ra_regrant_addr", bus.haddrs,       32'h44);
        tick();
        chk("ra_hreadyd",      32'(bus.hreadyd), 32'h1);
        chk("ra_hrdatad",      bus.hrdatad,      32'h00000077);
        bus.htransd = 1'b0;
        tick();

        // Address change after grant is not seen until the next grant
        bus.htransd = 1'b1;
        bus.haddrd  = 32'h10;
        bus.hreadys = 1'b0;
        tick();
        chk("hold_addr_a",  bus.haddrs, 32'h10);
        bus.haddrd  = 32'h20;
        tick();
        bus.hreadys = 1'b1;
        #1;
        chk("hold_addr_d",  bus.haddrs,       32'h10);
        chk("hold_hreadyd", 32'(bus.hreadyd), 32'h1);
        tick();
        chk("hold_addr_idle", bus.haddrs,       32'h10);
        chk("hold_idle_tr",   32'(bus.htranss), 32'h0);
        tick();
        chk("hold_addr_next", bus.haddrs,       32'h20);
        chk("hold_tr_next",   32'(bus.htranss), 32'h1);
        tick();
        bus.htransd = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #100000;
        n_fails++;
        $display("FAIL timeout: observed no end of test, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/nanorv32_busarb.md
NANORV32_BUSARB -- requirements
Module: nanorv32_busarb

Interface
REQ-001 SHALL have parameter MAX_D_STREAK, default 2: consecutive D-side grants allowed while I-side waits.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port htransi  input  1  I-side (fetch) request valid, held until completion.
REQ-005 SHALL have port haddri  input  32  I-side address, stable while htransi=1.
REQ-006 SHALL have port hreadyi  output  1  I-side ready/completion.
REQ-007 SHALL have port hrdatai  output  32  I-side read data, valid when hreadyi=1 with a request pending.
REQ-008 SHALL have port htransd  input  1  D-side request valid, held until completion.
REQ-009 SHALL have port hwrited  input  1  D-side write=1 / read=0.
REQ-010 SHALL have port haddrd  input  32  D-side address.
REQ-011 SHALL have port hsized  input  3  D-side size (AHB encoding).
REQ-012 SHALL have port hwdatad  input  32  D-side write data, stable while htransd=1.
REQ-013 SHALL have port hreadyd  output  1  D-side ready/completion.
REQ-014 SHALL have port hrdatad  output  32  D-side read data.
REQ-015 SHALL have ports htranss (output, 1), hwrites (output, 1), haddrs (output, 32), hsizes (output, 3), hwdatas (output, 32): shared slave-port request fields.
REQ-016 SHALL have ports hreadys (input, 1) and hrdatas (input, 32): shared slave-port completion and read data.

Function
REQ-017 SHALL implement FSM states IDLE, ADDR, DATA; reset state IDLE.
REQ-018 IDLE: if any request pending, SHALL grant one, latch its addr/size/write/wdata (I-side: write=0, size=3'b010) and go to ADDR next cycle; else stay IDLE.
REQ-019 ADDR: SHALL drive htranss=1 plus latched fields for exactly one cycle, then go to DATA.
REQ-020 DATA: SHALL hold htranss=0, hwdatas=latched wdata; stay until hreadys=1, then return to IDLE.
REQ-021 Completion cycle (DATA with hreadys=1): owner's hready SHALL be 1 and its hrdata SHALL equal hrdatas combinationally.
REQ-022 hreadyx SHALL be 1 when htransx=0, or on that master's completion cycle; 0 otherwise.
REQ-023 hrdatai/hrdatad SHALL be 0 outside their owner's completion cycle.
REQ-024 Minimum latency: request in IDLE cycle N, hreadys=1 -> completion at cycle N+2; each slave wait state adds one cycle.
REQ-025 Priority: D-side wins simultaneous requests unless D streak counter equals MAX_D_STREAK, then I-side wins.
REQ-026 Streak counter: +1 on each D grant while htransi=1; cleared on I grant or any grant with htransi=0; saturates at MAX_D_STREAK.
REQ-027 No back-to-back overlap: at most one transfer outstanding; IDLE bubble between transfers is required.
REQ-028 Request deasserted mid-transfer SHALL be ignored; latched transfer completes on slave port.
REQ-029 Changes to master inputs after grant SHALL NOT affect slave outputs until the next grant.
REQ-030 Idle slave outputs: htranss=0, hwrites=0; haddrs/hsizes/hwdatas keep last latched values.

Reset
REQ-031 rst=1 at a clock edge SHALL force: state IDLE, streak=0, latched fields=0, htranss=0, hwrites=0, no owner.
REQ-032 Reset during ADDR or DATA SHALL abort the transfer; no hready completion pulse is produced for it.
REQ-033 Outputs during/just after reset: hreadyi=~htransi, hreadyd=~htransd, hrdatai=hrdatad=0.

Verification
REQ-034 I-only read 0x100, hreadys=1, hrdatas=0x00000013 -> htranss=1 at N+1, hreadyi=1 with hrdatai=0x00000013 at N+2.
REQ-035 D write 0x20000004 data 0xCAFFE000 size 2, slave 3 wait states -> hwdatas=0xCAFFE000 throughout DATA, hreadyd at N+5.
REQ-036 Simultaneous I and D continuous requests, MAX_D_STREAK=2 -> grant order D,D,I,D,D,I; I never waits >2 transfers.
REQ-037 rst asserted in DATA with hreadys=0 -> next cycle IDLE, htranss=0, no hreadyd pulse; fresh request then serviced normally.
REQ-038 Master changes haddrd from 0x10 to 0x20 after grant -> haddrs stays 0x10; 0x20 issued only on next grant.
